fir_serial_sym: RTL and testbench

- Parametrised successor to the fully-parallel symmetric FIR filter: odd-length, linear-phase FIR using one pre-adder, one multiplier and one accumulator, time-multiplexed over the coefficient half-set.
- Runtime-loadable coefficients, sample-valid handshake, rounding and output saturation.
- Sits between the audio sample source and the output codec. The clock runs faster than the sample rate, and samples are marked by a valid strobe.

---
 rtl/fir_serial_sym.sv | 169 ++++++++++++++++
 tb/tb_fir_serial_sym.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_sym.sv
// Serial symmetric FIR: one pre-adder, one multiplier and one accumulator walk the
// M+1 folded coefficients per input sample, then round, saturate and emit one result.
module fir_serial_sym #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int TAPS      = 65,
  parameter int OUT_SHIFT = 15,
  parameter int ROUND     = 1,
  localparam int M        = (TAPS - 1) / 2,
  localparam int AW       = $clog2(M + 1)
) (
  input  logic                      sample_clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  input_sample,
  input  logic                      flush,
  input  logic                      coeff_we,
  input  logic [AW-1:0]             coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_data,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  FIR_output_sample,
  output logic                      out_sat
);

  localparam int PW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = DATA_W + COEFF_W + 1;
  localparam int ACC_W  = PROD_W + AW;

  localparam logic [ACC_W:0] RND =
    (ROUND != 0 && OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << (OUT_SHIFT - 1)) : '0;
  localparam logic signed [ACC_W:0] YMAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] YMIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                          state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0]     hist_q, hist_d;
  logic [M:0][COEFF_W-1:0]         coef_q, coef_d;
  logic [PW-1:0]                   wp_q, wp_d;
  logic [PW-1:0]                   ia_q, ia_d;
  logic [PW-1:0]                   ib_q, ib_d;
  logic [AW-1:0]                   k_q, k_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic                            in_ready_q, in_ready_d;
  logic                            out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]        y_q, y_d;
  logic                            sat_q, sat_d;

  logic [PW-1:0]                   wp_nxt;
  logic signed [DATA_W-1:0]        xa, xb;
  logic signed [COEFF_W-1:0]       cf;
  logic signed [PRE_W-1:0]         pre;
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_W:0]           rsum, rsh;
  logic signed [DATA_W-1:0]        y_clip;
  logic                            sat_clip;

  // ia walks back from x(n), ib walks forward from the oldest sample x(n-TAPS+1);
  // they meet at the centre tap, where only ia contributes.
  always_comb begin
    wp_nxt = (wp_q == PW'(TAPS - 1)) ? '0 : wp_q + PW'(1);
    xa     = hist_q[ia_q];
    xb     = (k_q == AW'(M)) ? '0 : hist_q[ib_q];
    cf     = coef_q[k_q];
    pre    = {xa[DATA_W-1], xa} + {xb[DATA_W-1], xb};
    prod   = pre * cf;
  end

  always_comb begin
    rsum = {acc_q[ACC_W-1], acc_q} + RND;
    rsh  = rsum >>> OUT_SHIFT;
    if (rsh > YMAX) begin
      y_clip   = {1'b0, {(DATA_W-1){1'b1}}};
      sat_clip = 1'b1;
    end else if (rsh < YMIN) begin
      y_clip   = {1'b1, {(DATA_W-1){1'b0}}};
      sat_clip = 1'b1;
    end else begin
      y_clip   = rsh[DATA_W-1:0];
      sat_clip = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    coef_d      = coef_q;
    wp_d        = wp_q;
    ia_d        = ia_q;
    ib_d        = ib_q;
    k_d         = k_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = 1'b0;
    y_d         = y_q;
    sat_d       = sat_q;
    case (state_q)
      IDLE: begin
        if (coeff_we && coeff_addr <= AW'(M)) coef_d[coeff_addr] = coeff_data;
        if (flush) begin
          hist_d = '0;
          wp_d   = '0;
        end else if (in_valid) begin
          hist_d[wp_q] = input_sample;
          ia_d         = wp_q;
          ib_d         = wp_nxt;
          wp_d         = wp_nxt;
          acc_d        = '0;
          k_d          = '0;
          in_ready_d   = 1'b0;
          state_d      = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{AW{prod[PROD_W-1]}}, prod};
        ia_d  = (ia_q == '0) ? PW'(TAPS - 1) : ia_q - PW'(1);
        ib_d  = (ib_q == PW'(TAPS - 1)) ? '0 : ib_q + PW'(1);
        k_d   = k_q + AW'(1);
        if (k_q == AW'(M)) state_d = OUT;
      end
      OUT: begin
        y_d         = y_clip;
        sat_d       = sat_clip;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sample_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      coef_q      <= '0;
      wp_q        <= '0;
      ia_q        <= '0;
      ib_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      wp_q        <= wp_d;
      ia_q        <= ia_d;
      ib_q        <= ib_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign FIR_output_sample = y_q;
  assign out_sat           = sat_q;

endmodule

// File: tb/tb_fir_serial_sym.sv
// Bench for fir_serial_sym (TAPS=5): a rounding and a truncating instance share stimulus
// and are compared against a direct-convolution reference model plus hand-derived vectors.
module tb_fir_serial_sym;
  localparam int DW = 16, CW = 16, TAPS = 5, M = 2, SH = 15, AW = 2;

  logic sample_clock = 1'b0;
  logic reset;
  logic in_valid, flush, coeff_we;
  logic signed [DW-1:0] input_sample;
  logic [AW-1:0] coeff_addr;
  logic signed [CW-1:0] coeff_data;
  logic in_ready, out_valid, out_sat;
  logic signed [DW-1:0] y;
  logic in_ready_t, out_valid_t, out_sat_t;
  logic signed [DW-1:0] y_t;

  always #5 sample_clock = ~sample_clock;

  fir_serial_sym #(.DATA_W(DW), .COEFF_W(CW), .TAPS(TAPS), .OUT_SHIFT(SH), .ROUND(1)) dut (
    .sample_clock(sample_clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_sample(input_sample), .flush(flush), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .out_valid(out_valid), .FIR_output_sample(y), .out_sat(out_sat));

  fir_serial_sym #(.DATA_W(DW), .COEFF_W(CW), .TAPS(TAPS), .OUT_SHIFT(SH), .ROUND(0)) dut_t (
    .sample_clock(sample_clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .input_sample(input_sample), .flush(flush), .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .out_valid(out_valid_t), .FIR_output_sample(y_t), .out_sat(out_sat_t));

  int checks = 0, errors = 0;
  int hq[$];          // past inputs, newest first
  int h[M+1];

  typedef struct { int x; int ey; bit es; } vec_t;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sample_clock);
  endtask

  // Direct convolution over the full mirrored tap set.
  function automatic longint model(bit rnd, output bit sat);
    longint acc, r;
    int xi, hi;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      xi = (i < hq.size()) ? hq[i] : 0;
      hi = h[(i <= M) ? i : TAPS - 1 - i];
      acc += longint'(hi) * longint'(xi);
    end
    r = (acc + (rnd ? (longint'(1) << (SH - 1)) : longint'(0))) >>> SH;
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return r;
  endfunction

  function automatic void push_x(int x);
    hq.push_front(x);
    if (hq.size() > TAPS) void'(hq.pop_back());
  endfunction

  task automatic load_coef(int a, int b, int c);
    int v[3];
    v = '{a, b, c};
    for (int k = 0; k <= M; k++) begin
      coeff_we = 1'b1; coeff_addr = AW'(k); coeff_data = v[k][CW-1:0]; h[k] = v[k];
      tick();
    end
    coeff_addr = AW'(3); coeff_data = 16'sd12345;   // out of range, must be dropped
    tick();
    coeff_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
    hq.delete();
  endtask

  task automatic send(input int x, input bit cw, input int ca, input int cd, input bit busy_cw,
                      output longint ay, output bit as);
    int n, lat;
    longint ey, ety;
    bit es, ets;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("send ready", in_ready, 1);
    in_valid = 1'b1; input_sample = x[DW-1:0];
    coeff_we = cw; coeff_addr = ca[AW-1:0]; coeff_data = cd[CW-1:0];
    if (cw && ca <= M) h[ca] = cd;
    push_x(x);
    ey = model(1'b1, es);
    ety = model(1'b0, ets);
    tick();
    in_valid = 1'b0; coeff_we = 1'b0;
    if (busy_cw) begin coeff_we = 1'b1; coeff_addr = AW'(1); coeff_data = 16'sd5; end
    lat = 0;
    do begin tick(); lat++; coeff_we = 1'b0; end while (!out_valid && lat < 20);
    check("latency", lat, M + 2);
    check("y round", y, ey);
    check("sat round", out_sat, es);
    check("valid trunc", out_valid_t, 1);
    check("y trunc", y_t, ety);
    check("sat trunc", out_sat_t, ets);
    ay = y; as = out_sat;
    tick();
    check("valid pulse", out_valid, 0);
  endtask

  task automatic stream(int nsamp);
    longint eq[$], etq[$];
    bit sq[$];
    int xs[$];
    int cyc, got, last, sent;
    longint e, et;
    bit s, st;
    logic [15:0] r16;
    for (int i = 0; i < nsamp; i++) begin r16 = 16'($urandom); xs.push_back(int'($signed(r16))); end
    cyc = 0; got = 0; last = -1; sent = 0;
    in_valid = 1'b1; input_sample = xs[0][DW-1:0];
    while ((sent < nsamp || got < nsamp) && cyc < 400) begin
      if (in_valid && in_ready) begin
        if (last >= 0) check("stream spacing", cyc - last, M + 3);
        last = cyc;
        push_x(xs[sent]);
        e = model(1'b1, s); et = model(1'b0, st);
        eq.push_back(e); sq.push_back(s); etq.push_back(et);
        sent++;
      end
      tick(); cyc++;
      if (sent < nsamp) input_sample = xs[sent][DW-1:0];
      else in_valid = 1'b0;
      if (out_valid) begin
        if (eq.size() == 0) check("stream spurious", 1, 0);
        else begin
          check("stream y", y, eq.pop_front());
          check("stream sat", out_sat, sq.pop_front());
          check("stream y trunc", y_t, etq.pop_front());
        end
        got++;
      end
    end
    in_valid = 1'b0;
    check("stream count", got, nsamp);
  endtask

  initial begin
    vec_t tv[6];
    longint ay;
    bit as;
    int nv;
    tv[0] = '{32767, 1000, 1'b0};
    tv[1] = '{0, 2000, 1'b0};
    tv[2] = '{0, 16384, 1'b0};
    tv[3] = '{0, 2000, 1'b0};
    tv[4] = '{0, 1000, 1'b0};
    tv[5] = '{0, 0, 1'b0};
    for (int k = 0; k <= M; k++) h[k] = 0;

    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; coeff_we = 1'b0;
    input_sample = '0; coeff_addr = '0; coeff_data = '0;
    tick(); tick();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset y", y, 0);
    check("reset sat", out_sat, 0);
    reset = 1'b1;
    tick();

    // impulse response
    load_coef(1000, 2000, 16384);
    foreach (tv[i]) begin
      send(tv[i].x, 1'b0, 0, 0, 1'b0, ay, as);
      check("impulse y", ay, tv[i].ey);
      check("impulse sat", as, tv[i].es);
    end

    // saturation, both rails
    load_coef(32767, 32767, 32767);
    send(32767, 1'b0, 0, 0, 1'b0, ay, as);
    check("sat first y", ay, 32766);
    check("sat first flag", as, 0);
    for (int i = 0; i < 4; i++) send(32767, 1'b0, 0, 0, 1'b0, ay, as);
    check("sat pos y", ay, 32767);
    check("sat pos flag", as, 1);
    for (int i = 0; i < 5; i++) send(-32768, 1'b0, 0, 0, 1'b0, ay, as);
    check("sat neg y", ay, -32768);
    check("sat neg flag", as, 1);

    // flush wins over in_valid and clears history
    load_coef(1000, 2000, 16384);
    for (int i = 0; i < 5; i++) send(1000, 1'b0, 0, 0, 1'b0, ay, as);
    flush = 1'b1; in_valid = 1'b1; input_sample = 16'sd1234;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    hq.delete();
    check("flush no accept", in_ready, 1);
    nv = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (out_valid) nv++; end
    check("flush no output", nv, 0);
    send(32767, 1'b0, 0, 0, 1'b0, ay, as);
    check("post flush y0", ay, 1000);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    check("post flush y1", ay, 2000);

    // coefficient write on the accept cycle takes effect, write while busy does not
    do_flush();
    load_coef(1000, 2000, 16384);
    send(32767, 1'b1, 0, 3000, 1'b1, ay, as);
    check("coef accept-cycle y", ay, 3000);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    check("coef busy ignored y", ay, 2000);

    // rounding vs truncation
    do_flush();
    load_coef(0, 0, 1);
    send(16384, 1'b0, 0, 0, 1'b0, ay, as);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    check("round +half", ay, 1);
    check("trunc +half", y_t, 0);
    send(-16384, 1'b0, 0, 0, 1'b0, ay, as);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    check("round -half", ay, 0);
    check("trunc -half", y_t, -1);

    // back-to-back random samples across many pointer wraps
    load_coef($urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
              $urandom_range(0, 16383) - 8192);
    stream(20);
    load_coef(32767, -32768, 32767);
    stream(12);

    // reset two cycles into a computation
    tick();
    in_valid = 1'b1; input_sample = 16'sd500;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset y", y, 0);
    check("midreset sat", out_sat, 0);
    tick();
    reset = 1'b1;
    hq.delete();
    for (int k = 0; k <= M; k++) h[k] = 0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) nv++; end
    check("midreset no output", nv, 0);
    send(32767, 1'b0, 0, 0, 1'b0, ay, as);
    check("coefs cleared y", ay, 0);
    load_coef(1000, 2000, 16384);
    send(0, 1'b0, 0, 0, 1'b0, ay, as);
    check("history cleared y", ay, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
